// File: rtl/jump_physics.sv
// -----------------------------------------------------------------------------
// jump_physics
//
// Responder side of the jump handshake with the game FSM. When i_jump_en
// rises the initial vertical velocity is latched (clamped to 127), then a
// discrete ballistic arc is integrated once per physics tick:
//     h_acc += vy; vy -= 1; dist += 1
// until the next step would take h_acc below zero, which is the landing.
// Distance and height are streamed to the FSM every tick; on landing
// o_jump_done is raised and held until the FSM drops i_jump_en.
//
// Ports:
//   clk_machine    in   1  system clock
//   rst_machine    in   1  asynchronous, active-high reset
//   i_jump_en      in   1  level request, high while a jump is wanted
//   i_jump_v_init  in  11  initial vertical velocity, sampled at launch
//   o_jump_dist    out 11  ticks elapsed since launch (0..255)
//   o_jump_height  out  9  current height, h_acc[13:5] (0..254)
//   o_jump_done    out  1  landed; held until i_jump_en goes low
//   o_busy         out  1  high while flying
//
// Parameter:
//   TICK_DIV  clk_machine cycles per physics tick, must be >= 2
// -----------------------------------------------------------------------------
module jump_physics #(
    parameter int unsigned TICK_DIV = 100000
) (
    input  logic        clk_machine,
    input  logic        rst_machine,
    input  logic        i_jump_en,
    input  logic [10:0] i_jump_v_init,
    output logic [10:0] o_jump_dist,
    output logic [8:0]  o_jump_height,
    output logic        o_jump_done,
    output logic        o_busy
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FLY  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Clamp the requested launch velocity to 7 bits; this bound is what
    // keeps h_acc within 14 bits, vy >= -128 and dist <= 255.
    function automatic logic [6:0] clamp_v(input logic [10:0] v_in);
        logic [6:0] v_out;
        if (v_in > 11'd127) begin
            v_out = 7'd127;
        end else begin
            v_out = v_in[6:0];
        end
        return v_out;
    endfunction

    // Signed 15-bit sum h_acc + vy; bit 14 set means the arc would go
    // below ground on this tick.
    function automatic logic [14:0] arc_sum(input logic [13:0] h_in,
                                            input logic [8:0]  vy_in);
        return {1'b0, h_in} + {{6{vy_in[8]}}, vy_in};
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic signed [8:0]  vy_q, vy_d;
    logic [13:0]        h_acc_q, h_acc_d;
    logic [7:0]         dist_q, dist_d;
    logic [8:0]         height_q, height_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    logic [14:0]        sum_s;
    logic               tick_s;
    logic [6:0]         v_clamp_s;

    // Next-state and datapath update for the IDLE / FLY / DONE handshake.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        vy_d      = vy_q;
        h_acc_d   = h_acc_q;
        dist_d    = dist_q;
        sum_s     = arc_sum(h_acc_q, vy_q);
        tick_s    = (cnt_q == TICK_LAST);
        v_clamp_s = clamp_v(i_jump_v_init);

        case (state_q)
            ST_IDLE: begin
                h_acc_d = 14'd0;
                cnt_d   = CNT_ZERO;
                if (i_jump_en) begin
                    // Launch: distance is only cleared here, so it holds
                    // its last value through IDLE.
                    state_d = ST_FLY;
                    vy_d    = $signed({2'b00, v_clamp_s});
                    dist_d  = 8'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_FLY: begin
                if (!i_jump_en) begin
                    // Abort wins over a coincident tick; height drops to
                    // ground, distance keeps its last value.
                    state_d = ST_IDLE;
                    h_acc_d = 14'd0;
                    cnt_d   = CNT_ZERO;
                end else if (tick_s) begin
                    cnt_d = CNT_ZERO;
                    if (sum_s[14]) begin
                        state_d = ST_DONE;
                        h_acc_d = 14'd0;
                    end else begin
                        h_acc_d = sum_s[13:0];
                        vy_d    = vy_q - 9'sd1;
                        dist_d  = dist_q + 8'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_DONE: begin
                // A held-high request does not retrigger; the FSM must
                // drop i_jump_en first.
                if (!i_jump_en) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                h_acc_d = 14'd0;
                cnt_d   = CNT_ZERO;
            end
        endcase

        // Outputs are registered copies of the next state so they move on
        // the same edge as the state itself.
        height_d = h_acc_d[13:5];
        busy_d   = (state_d == ST_FLY);
        done_d   = (state_d == ST_DONE);
    end

    // State, arc accumulators and registered outputs.
    always_ff @(posedge clk_machine or posedge rst_machine) begin
        if (rst_machine) begin
            state_q  <= ST_IDLE;
            cnt_q    <= CNT_ZERO;
            vy_q     <= 9'sd0;
            h_acc_q  <= 14'd0;
            dist_q   <= 8'd0;
            height_q <= 9'd0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            vy_q     <= vy_d;
            h_acc_q  <= h_acc_d;
            dist_q   <= dist_d;
            height_q <= height_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign o_jump_dist   = {3'b000, dist_q};
    assign o_jump_height = height_q;
    assign o_jump_done   = done_q;
    assign o_busy        = busy_q;

endmodule

// File: tb/tb_jump_physics.sv
// -----------------------------------------------------------------------------
// tb_jump_physics
//
// Directed bench for jump_physics with TICK_DIV = 2. A table of launch
// velocities with hand-computed landing cycle, final distance and peak
// height is run back to back through the full handshake; the per-cycle
// trace is compared against the closed-form arc
//     h_acc(k) = k*v - k*(k-1)/2  after update k.
// Hand-written sequences cover abort, reset mid-flight and the initial
// reset state.
// -----------------------------------------------------------------------------
module tb_jump_physics;

    localparam int TD = 2;

    logic        clk_machine;
    logic        rst_machine;
    logic        i_jump_en;
    logic [10:0] i_jump_v_init;
    logic [10:0] o_jump_dist;
    logic [8:0]  o_jump_height;
    logic        o_jump_done;
    logic        o_busy;

    int errors;
    int checks;

    jump_physics #(.TICK_DIV(TD)) dut (
        .clk_machine   (clk_machine),
        .rst_machine   (rst_machine),
        .i_jump_en     (i_jump_en),
        .i_jump_v_init (i_jump_v_init),
        .o_jump_dist   (o_jump_dist),
        .o_jump_height (o_jump_height),
        .o_jump_done   (o_jump_done),
        .o_busy        (o_busy)
    );

    initial clk_machine = 1'b0;
    always #5 clk_machine = ~clk_machine;

    typedef struct {
        logic [10:0] v_init;     // value driven on i_jump_v_init
        int          v_eff;      // clamped velocity
        int          dist_final; // 2v+1
        int          peak;       // (v(v+1)/2) >> 5
        int          done_cyc;   // (2v+2)*TD edges after launch
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock edge, then settle before sampling.
    task automatic step();
        @(posedge clk_machine);
        #1;
    endtask

    function automatic int exp_h(input int v, input int k);
        return (k * v - (k * (k - 1)) / 2) / 32;
    endfunction

    // Full jump: launch, trace, landing, 100-cycle hold with en high,
    // then release. Leaves i_jump_en low with the DUT in IDLE.
    task automatic run_jump(input vec_t t);
        int c;
        int k;
        int trace_err;
        int hold_err;
        int peak;
        bit landed;

        i_jump_v_init = t.v_init;
        i_jump_en     = 1'b1;
        step();
        check("launch_busy", {31'd0, o_busy}, 32'd1);
        check("launch_dist", {21'd0, o_jump_dist}, 32'd0);
        // Velocity changes after launch must have no effect.
        i_jump_v_init = 11'd1;

        c = 0; trace_err = 0; peak = 0; landed = 1'b0;
        while (!landed && c < 2000) begin
            step();
            c++;
            if (o_jump_done) begin
                landed = 1'b1;
            end else begin
                k = c / TD;
                if (o_jump_dist !== 11'(k) ||
                    o_jump_height !== 9'(exp_h(t.v_eff, k)) ||
                    o_busy !== 1'b1) begin
                    if (trace_err < 3)
                        $display("trace v=%0d c=%0d dist=%0d h=%0d busy=%0b",
                                 t.v_eff, c, o_jump_dist, o_jump_height, o_busy);
                    trace_err++;
                end
                if (int'(o_jump_height) > peak) peak = int'(o_jump_height);
            end
        end
        check("trace", trace_err, 0);
        check("done_cycle", c, t.done_cyc);
        check("final_dist", {21'd0, o_jump_dist}, t.dist_final);
        check("land_height", {23'd0, o_jump_height}, 32'd0);
        check("land_busy", {31'd0, o_busy}, 32'd0);
        check("peak", peak, t.peak);

        hold_err = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (o_jump_done !== 1'b1 || o_busy !== 1'b0 ||
                o_jump_dist !== 11'(t.dist_final) || o_jump_height !== 9'd0)
                hold_err++;
        end
        check("hold_frozen", hold_err, 0);

        i_jump_en = 1'b0;
        step();
        check("release_done", {31'd0, o_jump_done}, 32'd0);
        check("release_busy", {31'd0, o_busy}, 32'd0);
        check("release_dist", {21'd0, o_jump_dist}, t.dist_final);
    endtask

    initial begin
        int wait_c;
        int idle_err;

        errors = 0;
        checks = 0;

        vecs[0] = '{11'd127, 127, 255, 254, 512};
        vecs[1] = '{11'd0,     0,   1,   0,   4};
        vecs[2] = '{11'd2,     2,   5,   0,  12};
        vecs[3] = '{11'd500, 127, 255, 254, 512};
        vecs[4] = '{11'd10,   10,  21,   1,  44};
        vecs[5] = '{11'd63,   63, 127,  63, 256};
        vecs[6] = '{11'd64,   64, 129,  65, 260};
        vecs[7] = '{11'd128, 127, 255, 254, 512};

        rst_machine   = 1'b1;
        i_jump_en     = 1'b0;
        i_jump_v_init = 11'd0;
        repeat (3) @(posedge clk_machine);
        #1;
        check("rst_dist",   {21'd0, o_jump_dist},   32'd0);
        check("rst_height", {23'd0, o_jump_height}, 32'd0);
        check("rst_done",   {31'd0, o_jump_done},   32'd0);
        check("rst_busy",   {31'd0, o_busy},        32'd0);
        @(negedge clk_machine);
        rst_machine = 1'b0;
        step();

        // Table-driven jumps, each relaunching one edge after release.
        for (int n = 0; n < 8; n++) begin
            run_jump(vecs[n]);
        end

        // Abort: v=100, drop en right after the 10th tick.
        i_jump_v_init = 11'd100;
        i_jump_en     = 1'b1;
        step();
        for (int i = 0; i < 10 * TD; i++) step();
        check("abort_pre_dist",   {21'd0, o_jump_dist},   32'd10);
        check("abort_pre_height", {23'd0, o_jump_height}, 32'd29);
        i_jump_en = 1'b0;
        step();
        check("abort_height", {23'd0, o_jump_height}, 32'd0);
        check("abort_dist",   {21'd0, o_jump_dist},   32'd10);
        check("abort_busy",   {31'd0, o_busy},        32'd0);
        check("abort_done",   {31'd0, o_jump_done},   32'd0);
        idle_err = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (o_jump_done !== 1'b0 || o_busy !== 1'b0 ||
                o_jump_dist !== 11'd10 || o_jump_height !== 9'd0)
                idle_err++;
        end
        check("abort_idle_hold", idle_err, 0);
        run_jump('{11'd3, 3, 7, 0, 16});

        // Reset mid-flight at dist=50, then fresh launch with en held high.
        i_jump_v_init = 11'd127;
        i_jump_en     = 1'b1;
        step();
        wait_c = 0;
        while (o_jump_dist !== 11'd50 && wait_c < 300) begin
            step();
            wait_c++;
        end
        check("rst_mid_reach50", {21'd0, o_jump_dist}, 32'd50);
        rst_machine = 1'b1;
        #1;
        check("rst_mid_dist",   {21'd0, o_jump_dist},   32'd0);
        check("rst_mid_height", {23'd0, o_jump_height}, 32'd0);
        check("rst_mid_busy",   {31'd0, o_busy},        32'd0);
        check("rst_mid_done",   {31'd0, o_jump_done},   32'd0);
        @(negedge clk_machine);
        rst_machine = 1'b0;
        step();
        check("rst_relaunch_busy", {31'd0, o_busy},      32'd1);
        check("rst_relaunch_dist", {21'd0, o_jump_dist}, 32'd0);
        for (int i = 0; i < TD; i++) step();
        check("rst_relaunch_tick1", {21'd0, o_jump_dist}, 32'd1);
        i_jump_en = 1'b0;
        step();
        check("rst_relaunch_abort", {31'd0, o_busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
